// File: rtl/rng_call_arbiter.sv
// rng_call_arbiter
//   Shares one rng word stream among NREQ passenger call generators. Each
//   granted requester gets a uniformly distributed floor in [0, NUM_FLOORS-1]
//   by rejection sampling the low FLOOR_W bits of the rng word. One rng word is
//   looked at per SAMPLE cycle, so two grants never see the same word.
//
// Ports
//   clk          system clock
//   rst          asynchronous active-low reset
//   rand_in      current rng word, new value every clock
//   req          level request per requester
//   ack          requester has consumed its floor_out slot
//   valid        slot i holds an unconsumed result
//   floor_out    slot i at bits [i*FLOOR_W +: FLOOR_W]
//   busy         FSM is in SAMPLE
//   reject_cnt   total rejected draws, saturating at 255
//   stuck        sticky: a fallback result was issued since reset
//   dbg_state_o  FSM state (0 = IDLE, 1 = SAMPLE)
//   dbg_rr_ptr_o round-robin pointer (last granted requester)
//
// Handshake: a slot result is offered by valid[i]=1 together with its
// floor_out slot; the requester takes it by holding ack[i]=1 for one cycle,
// and valid[i] drops at that edge. ack[i] with valid[i]=0 does nothing. A
// requester is only considered for a new grant while req[i]=1 and valid[i]=0.
module rng_call_arbiter #(
  parameter int NREQ       = 4,
  parameter int RAND_W     = 12,
  parameter int NUM_FLOORS = 10,
  parameter int FLOOR_W    = 4,
  parameter int MAX_REJECT = 15
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [RAND_W-1:0]         rand_in,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ-1:0]           ack,
  output logic [NREQ-1:0]           valid,
  output logic [NREQ*FLOOR_W-1:0]   floor_out,
  output logic                      busy,
  output logic [7:0]                reject_cnt,
  output logic                      stuck,
  output logic                      dbg_state_o,
  output logic [$clog2(NREQ)-1:0]   dbg_rr_ptr_o
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_REJECT + 1);

  typedef enum logic {
    S_IDLE   = 1'b0,
    S_SAMPLE = 1'b1
  } state_t;

  state_t                    state_q, state_d;
  logic [IW-1:0]             win_q, win_d;
  logic [IW-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]             consec_q, consec_d;
  logic [NREQ-1:0]           valid_q, valid_d;
  logic [NREQ*FLOOR_W-1:0]   floor_q, floor_d;
  logic [7:0]                rej_q, rej_d;
  logic                      stuck_q, stuck_d;

  logic [NREQ-1:0]           elig;
  logic                      found;
  logic [IW-1:0]             pick;
  logic [FLOOR_W-1:0]        cand;
  logic                      cand_ok;
  logic [7:0]                rej_inc;

  // Only the low FLOOR_W bits of the rng word are used as the candidate.
  logic unused_rand;
  assign unused_rand = ^rand_in[RAND_W-1:FLOOR_W];

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    elig  = req & ~valid_q;
    found = 1'b0;
    pick  = '0;
    for (int k = 1; k <= NREQ; k++) begin
      int          idx;
      logic [IW-1:0] idx_v;
      idx   = (int'(rr_ptr_q) + k) % NREQ;
      idx_v = IW'(idx);
      if (!found && elig[idx_v]) begin
        found = 1'b1;
        pick  = idx_v;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_ptr_d = rr_ptr_q;
    consec_d = consec_q;
    floor_d  = floor_q;
    rej_d    = rej_q;
    stuck_d  = stuck_q;
    // ack only clears bits that are actually set; a stray ack is a no-op.
    valid_d  = valid_q & ~ack;
    cand     = rand_in[FLOOR_W-1:0];
    cand_ok  = ({1'b0, cand} < (FLOOR_W+1)'(NUM_FLOORS));
    rej_inc  = (rej_q == 8'hFF) ? rej_q : rej_q + 8'd1;

    case (state_q)
      S_IDLE: begin
        if (found) begin
          win_d    = pick;
          consec_d = '0;
          state_d  = S_SAMPLE;
        end
      end
      S_SAMPLE: begin
        if (!req[win_q]) begin
          // Withdrawal wins over everything: nothing is recorded.
          state_d = S_IDLE;
        end else if (cand_ok) begin
          floor_d[int'(win_q)*FLOOR_W +: FLOOR_W] = cand;
          valid_d[win_q] = 1'b1;
          rr_ptr_d       = win_q;
          state_d        = S_IDLE;
        end else if (consec_q == CW'(MAX_REJECT - 1)) begin
          // Too many misses in a row: hand out floor 0 so the requester is
          // never starved, and remember that it happened.
          floor_d[int'(win_q)*FLOOR_W +: FLOOR_W] = '0;
          valid_d[win_q] = 1'b1;
          stuck_d        = 1'b1;
          rr_ptr_d       = win_q;
          rej_d          = rej_inc;
          state_d        = S_IDLE;
        end else begin
          consec_d = consec_q + CW'(1);
          rej_d    = rej_inc;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= S_IDLE;
      win_q    <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      consec_q <= '0;
      valid_q  <= '0;
      floor_q  <= '0;
      rej_q    <= '0;
      stuck_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_ptr_q <= rr_ptr_d;
      consec_q <= consec_d;
      valid_q  <= valid_d;
      floor_q  <= floor_d;
      rej_q    <= rej_d;
      stuck_q  <= stuck_d;
    end
  end

  assign valid        = valid_q;
  assign floor_out    = floor_q;
  assign busy         = (state_q == S_SAMPLE);
  assign reject_cnt   = rej_q;
  assign stuck        = stuck_q;
  assign dbg_state_o  = state_q;
  assign dbg_rr_ptr_o = rr_ptr_q;

endmodule

// File: tb/tb_rng_call_arbiter.sv
module tb_rng_call_arbiter;

  logic        clk;
  logic        rst;
  logic [11:0] rand_in;
  logic [3:0]  req;
  logic [3:0]  ack;
  logic [3:0]  valid;
  logic [15:0] floor_out;
  logic        busy;
  logic [7:0]  reject_cnt;
  logic        stuck;
  logic        dbg_state;
  logic [1:0]  dbg_rr_ptr;

  int errors = 0;
  int checks = 0;

  // Expected grant: {requester index[1:0], floor[3:0]}
  logic [5:0] exp_q[$];

  rng_call_arbiter #(
    .NREQ(4), .RAND_W(12), .NUM_FLOORS(10), .FLOOR_W(4), .MAX_REJECT(15)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .rand_in     (rand_in),
    .req         (req),
    .ack         (ack),
    .valid       (valid),
    .floor_out   (floor_out),
    .busy        (busy),
    .reject_cnt  (reject_cnt),
    .stuck       (stuck),
    .dbg_state_o (dbg_state),
    .dbg_rr_ptr_o(dbg_rr_ptr)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_valid"},  valid, 4'b0000);
    check({tag, "_floor"},  floor_out, 16'h0000);
    check({tag, "_busy"},   busy, 1'b0);
    check({tag, "_rejcnt"}, reject_cnt, 8'd0);
    check({tag, "_stuck"},  stuck, 1'b0);
    check({tag, "_rrptr"},  dbg_rr_ptr, 2'd3);
    check({tag, "_state"},  dbg_state, 1'b0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  // A grant is a valid bit that was low at the previous sample and is high now.
  initial begin
    logic [3:0] prev_valid;
    logic [3:0] new_bits;
    logic [5:0] got;
    logic [5:0] e;
    prev_valid = '0;
    forever begin
      @(negedge clk);
      new_bits = valid & ~prev_valid;
      for (int i = 0; i < 4; i++) begin
        if (new_bits[i]) begin
          got = {2'(i), floor_out[i*4 +: 4]};
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_grant: got req=%0d floor=%0d, required no grant",
                     got[5:4], got[3:0]);
          end else begin
            e = exp_q.pop_front();
            if (got !== e) begin
              errors++;
              $display("FAIL grant: got req=%0d floor=%0d, required req=%0d floor=%0d",
                       got[5:4], got[3:0], e[5:4], e[3:0]);
            end
          end
        end
      end
      prev_valid = valid;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int  bc;
    logic [7:0] prev_rej;
    logic wrapped;

    rst = 1'b0; req = '0; ack = '0; rand_in = '0;
    tick(); tick();
    check_reset("reset0");
    @(negedge clk); rst = 1'b1;
    tick();

    // Single requester: accept on first draw.
    req = 4'b0001; rand_in = 12'h3A7;
    exp_q.push_back(6'h07);
    tick();
    check("single_busy_on", busy, 1'b1);
    check("single_valid_early", valid, 4'b0000);
    tick();
    check("single_busy_off", busy, 1'b0);
    check("single_valid", valid, 4'b0001);
    check("single_floor0", floor_out[3:0], 4'd7);
    ack = 4'b0001; req = '0;
    tick();
    check("single_ack_clears", valid, 4'b0000);
    check("single_floor_kept", floor_out[3:0], 4'd7);
    ack = '0;

    // Rejection: 15 and 12 rejected, 5 accepted.
    req = 4'b0100; rand_in = 12'h00F;
    exp_q.push_back(6'h25);
    bc = 0;
    tick(); bc += int'(busy);
    tick(); bc += int'(busy);
    rand_in = 12'h00C;
    tick(); bc += int'(busy);
    rand_in = 12'h005;
    tick(); bc += int'(busy);
    check("rej_busy_cycles", bc, 3);
    check("rej_cnt", reject_cnt, 8'd2);
    check("rej_stuck", stuck, 1'b0);
    check("rej_valid", valid, 4'b0100);
    check("rej_floor2", floor_out[11:8], 4'd5);
    ack = 4'b0100; req = '0;
    tick();
    ack = '0;

    // Withdraw during rejection, then a stray ack.
    req = 4'b1000; rand_in = 12'h00E;
    tick();
    check("wd_busy", busy, 1'b1);
    tick();
    req = '0;
    tick();
    check("wd_idle", busy, 1'b0);
    check("wd_valid", valid, 4'b0000);
    check("wd_rrptr", dbg_rr_ptr, 2'd2);
    check("wd_rejcnt", reject_cnt, 8'd3);
    tick();
    check("wd_stay_idle", dbg_state, 1'b0);
    ack = 4'b0001;
    tick();
    check("ackign_valid", valid, 4'b0000);
    check("ackign_busy", busy, 1'b0);
    ack = '0;

    // Fresh reset, then round robin with everyone requesting.
    rst = 1'b0;
    tick(); tick();
    check_reset("reset1");
    @(negedge clk); rst = 1'b1;
    tick();
    req = 4'b1111; rand_in = 12'h001;
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 4; i++)
        exp_q.push_back({2'(i), 4'd1});
    for (int n = 0; n < 16; n++) begin
      tick();
      ack = valid;
    end
    req = '0;
    tick();
    ack = '0;
    check("rr_valid_done", valid, 4'b0000);
    check("rr_rejcnt", reject_cnt, 8'd0);
    check("rr_rrptr", dbg_rr_ptr, 2'd3);

    // Fallback after 15 consecutive rejections.
    req = 4'b0010; rand_in = 12'hFFF;
    exp_q.push_back(6'h10);
    bc = 0;
    for (int n = 0; n < 16; n++) begin
      tick();
      bc += int'(busy);
    end
    check("fb_busy_cycles", bc, 15);
    check("fb_valid", valid, 4'b0010);
    check("fb_floor1", floor_out[7:4], 4'd0);
    check("fb_stuck", stuck, 1'b1);
    check("fb_rejcnt", reject_cnt, 8'd15);
    check("fb_busy_off", busy, 1'b0);

    // Keep going until the reject counter saturates (21 fallbacks total).
    for (int n = 0; n < 20; n++) exp_q.push_back(6'h10);
    ack = valid;
    prev_rej = reject_cnt;
    wrapped = 1'b0;
    for (int n = 0; n < 340; n++) begin
      tick();
      ack = valid;
      if (reject_cnt < prev_rej) wrapped = 1'b1;
      prev_rej = reject_cnt;
    end
    req = '0;
    tick();
    ack = '0;
    check("sat_rejcnt", reject_cnt, 8'd255);
    check("sat_no_wrap", wrapped, 1'b0);
    check("sat_stuck", stuck, 1'b1);

    // Async reset in the middle of SAMPLE.
    req = 4'b0001; rand_in = 12'hFFF;
    tick();
    check("mid_busy", busy, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_reset("reset_mid");
    req = 4'b1111; rand_in = 12'h005;
    exp_q.push_back(6'h05);
    @(negedge clk); rst = 1'b1;
    tick();
    check("post_rst_win", busy, 1'b1);
    tick();
    check("post_rst_valid", valid, 4'b0001);
    check("post_rst_floor0", floor_out[3:0], 4'd5);
    req = '0; ack = valid;
    tick();
    ack = '0;
    tick();

    check("queue_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rng_call_arbiter.md
Name: rng_call_arbiter

Overview:
- Shares the single `rng` word stream (12-bit `randy`) among NREQ simulated-passenger call generators.
- Each requester receives a fresh, uniformly distributed floor number in [0, NUM_FLOORS-1], produced by rejection sampling.
- Sits between `rng` and the hall-call injection logic used for stimulus and demo mode in the elevator controller.
- One rng word is consumed per sampling cycle, so no two grants ever see the same word.

Parameters:
NREQ, 4, number of requesters (2..8)
RAND_W, 12, width of rng word
NUM_FLOORS, 10, legal floor count (2..2**FLOOR_W)
FLOOR_W, 4, floor index width; must satisfy 2**FLOOR_W >= NUM_FLOORS
MAX_REJECT, 15, consecutive rejections before fallback

Ports:
clk  in  1  system clock (~750 kHz)
rst  in  1  asynchronous, active-low reset
rand_in  in  RAND_W  current rng word (`randy`); changes every clock
req  in  NREQ  level request per requester
ack  in  NREQ  requester has consumed its floor_out; clears valid
valid  out  NREQ  floor_out slot i holds an unconsumed result
floor_out  out  NREQ*FLOOR_W  slot i at bits [i*FLOOR_W +: FLOOR_W]
busy  out  1  FSM is in SAMPLE
reject_cnt  out  8  total rejected draws, saturating at 255
stuck  out  1  sticky: a fallback occurred since reset

Behaviour:
- Reset (rst=0, async):
  - state=IDLE; valid=0, floor_out=0, busy=0, reject_cnt=0, stuck=0.
  - rr_ptr=NREQ-1, so requester 0 has first priority; consec=0.
- Eligibility: eligible[i] = req[i] & ~valid[i].
- IDLE:
  - If any eligible requester: pick the first eligible index searching rr_ptr+1, rr_ptr+2, … (mod NREQ).
  - Register it as `win`, clear consec, go to SAMPLE.
  - Otherwise stay in IDLE.
- SAMPLE (busy=1): cand = rand_in[FLOOR_W-1:0].
  - req[win]=0 (requester withdrew) takes priority over all other cases: abandon, go to IDLE. rr_ptr and reject_cnt are unchanged.
  - Else if cand < NUM_FLOORS: floor_out[win]<=cand, valid[win]<=1, rr_ptr<=win, go to IDLE.
  - Else if consec == MAX_REJECT-1: fallback.
    - floor_out[win]<=0, valid[win]<=1, stuck<=1, rr_ptr<=win, go to IDLE.
    - reject_cnt still increments.
  - Else reject: consec++, reject_cnt++ (saturating), stay in SAMPLE. The next clock presents a new rng word.
- Latency:
  - req rises at edge N, seen in IDLE → SAMPLE at edge N+1.
  - On accept, valid is high after edge N+2.
  - Throughput is at most one grant per 2 cycles.
- Ack:
  - ack[i] & valid[i] clears valid[i] at the next edge.
  - ack[i] while valid[i]=0 is ignored.
  - A requester may re-request immediately; it becomes eligible the cycle after its valid clears.
- Simultaneous events:
  - ack[j] while the FSM accepts for win=i≠j: both take effect.
  - ack[win] cannot coincide with an accept, because win had valid=0 when granted.
- Outputs:
  - floor_out[i] holds its value until the next accept for i; it is not cleared on ack.
  - All outputs are registered; nothing combinational goes from req/ack to the outputs.
- Reset mid-SAMPLE: immediate return to the reset values. No partial result survives.

Test Plan:
- Single requester:
  - Stimulus: after rst release, req=4'b0001, rand_in=12'h3A7 (cand 7).
  - Expected: valid=4'b0001 and floor_out[0]=7 two edges after req; busy is high for exactly 1 cycle.
  - Assert ack → valid=0 next edge.
- Rejection:
  - Stimulus: req[2]=1, rand_in sequence 12'h00F, 12'h00C, 12'h005.
  - Expected: floor_out[2]=5, reject_cnt=2, stuck=0, busy high for 3 cycles.
- Round-robin:
  - Stimulus: req=4'b1111 held; rand_in=12'h001 constant; ack each valid the cycle it appears.
  - Expected: grant order 0,1,2,3,0,…; no requester is granted twice before all four have been granted.
- Fallback:
  - Stimulus: req[1]=1, rand_in=12'hFFF constant.
  - Expected: after 15 SAMPLE cycles, valid[1]=1, floor_out[1]=0, stuck=1, reject_cnt=15.
  - With the same stimulus continued, reject_cnt saturates at 255 and never wraps.
- Withdraw and ack-ignore:
  - Stimulus: req[3] drops while SAMPLE is rejecting rand_in=12'h00E.
  - Expected: FSM returns to IDLE, valid[3] stays 0, rr_ptr is unchanged.
  - Stimulus: ack[0] with valid[0]=0 → expected: no effect.
- Async reset mid-SAMPLE:
  - Stimulus: pull rst low between clock edges while busy=1.
  - Expected: all outputs reach their reset values immediately, without waiting for a clock edge.
  - Expected after release: req[0] is served first.
